// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spike output stage.
package snn_pkg;

  localparam int N_CLASS_DEF = 8;
  localparam int CNT_W_DEF   = 8;
  localparam int IDX_W_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } dec_state_e;

  // Per-class spike counts at the default sizing
  typedef logic [N_CLASS_DEF-1:0][CNT_W_DEF-1:0] cnt_vec_t;

endpackage

// File: rtl/spike_counter_bank.sv
// N_CLASS saturating spike counters with a shared clear and enable.
// cnt is the registered count; cnt_next is the value after this cycle's update.
module spike_counter_bank
  import snn_pkg::*;
#(
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clr,
  input  logic                            en,
  input  logic [N_CLASS-1:0]              spike,
  output logic [N_CLASS-1:0][CNT_W-1:0]   cnt,
  output logic [N_CLASS-1:0][CNT_W-1:0]   cnt_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < N_CLASS; i++) begin : g_lane
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins; otherwise count a spike unless already pinned at max
    always_comb begin
      cnt_d = cnt_q;
      if (clr)
        cnt_d = '0;
      else if (en && spike[i] && (cnt_q != CNT_MAX))
        cnt_d = cnt_q + 1'b1;
    end

    // Lane counter register
    always_ff @(posedge clk) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign cnt[i]      = cnt_q;
    assign cnt_next[i] = cnt_d;
  end

endmodule

// File: rtl/spike_decoder.sv
// Spike-count classifier: accumulates WINDOW timesteps of output spikes,
// scans the counts one class per cycle for the argmax, and pulses the
// result for one cycle.
// Optional: SPIKE_DECODER_EARLY_EXIT_EN ends the window as soon as any
// class count reaches EARLY_THRESH.
module spike_decoder
  import snn_pkg::*;
#(
  parameter int          N_CLASS      = N_CLASS_DEF,
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned WINDOW       = 100,
  parameter int          IDX_W        = IDX_W_DEF,
  parameter int unsigned EARLY_THRESH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [N_CLASS-1:0] input_spike,
  output logic               busy,
  output logic               out_valid,
  output logic [IDX_W-1:0]   class_idx,
  output logic [CNT_W-1:0]   class_count,
  output logic               tie
);

  localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(N_CLASS - 1);
  localparam logic [15:0]      LAST_STP = 16'(WINDOW - 1);

  dec_state_e state_q, state_d;
  logic [15:0]      step_q, step_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             run_tie_q, run_tie_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] class_idx_q, class_idx_d;
  logic [CNT_W-1:0] class_count_q, class_count_d;
  logic             tie_q, tie_d;

  logic [N_CLASS-1:0][CNT_W-1:0] cnt, cnt_next;
  logic bank_clr, bank_en, last_step, early_hit;
  logic [CNT_W-1:0] cur;

  assign bank_clr  = (state_q == IDLE) && start;
  assign bank_en   = (state_q == ACCUM) && in_valid;
  assign last_step = bank_en && (step_q == LAST_STP);

  spike_counter_bank #(
    .N_CLASS (N_CLASS),
    .CNT_W   (CNT_W)
  ) u_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (bank_clr),
    .en       (bank_en),
    .spike    (input_spike),
    .cnt      (cnt),
    .cnt_next (cnt_next)
  );

`ifdef SPIKE_DECODER_EARLY_EXIT_EN
  logic early_any;
  // Any class reaching the threshold with this update closes the window
  always_comb begin
    early_any = 1'b0;
    for (int i = 0; i < N_CLASS; i++)
      if (32'(cnt_next[i]) >= EARLY_THRESH) early_any = 1'b1;
  end
  assign early_hit = bank_en && early_any;
`else
  logic unused_early;
  assign unused_early = ^{32'(EARLY_THRESH), cnt_next};
  assign early_hit    = 1'b0;
`endif

  // Next-state, scan datapath and result registers
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    k_d           = k_q;
    max_idx_d     = max_idx_q;
    max_d         = max_q;
    run_tie_d     = run_tie_q;
    out_valid_d   = 1'b0;
    class_idx_d   = class_idx_q;
    class_count_d = class_count_q;
    tie_d         = tie_q;
    cur           = cnt[k_q];
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          step_d  = '0;
        end
      end
      ACCUM: begin
        if (bank_en) begin
          step_d = step_q + 16'd1;
          if (last_step || early_hit) begin
            state_d = SCAN;
            k_d     = '0;
          end
        end
      end
      SCAN: begin
        if (k_q == '0) begin
          max_d     = cur;
          max_idx_d = '0;
          run_tie_d = 1'b0;
        end else if (cur > max_q) begin
          max_d     = cur;
          max_idx_d = k_q;
          run_tie_d = 1'b0;
        end else if (cur == max_q) begin
          run_tie_d = 1'b1;
        end
        if (k_q == LAST_K) state_d = DONE;
        else               k_d     = k_q + 1'b1;
      end
      DONE: begin
        state_d       = IDLE;
        out_valid_d   = 1'b1;
        class_idx_d   = max_idx_q;
        class_count_d = max_q;
        tie_d         = run_tie_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ACCUM) || (state_d == SCAN);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      step_q        <= '0;
      k_q           <= '0;
      max_idx_q     <= '0;
      max_q         <= '0;
      run_tie_q     <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      class_idx_q   <= '0;
      class_count_q <= '0;
      tie_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      k_q           <= k_d;
      max_idx_q     <= max_idx_d;
      max_q         <= max_d;
      run_tie_q     <= run_tie_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      class_idx_q   <= class_idx_d;
      class_count_q <= class_count_d;
      tie_q         <= tie_d;
    end
  end

  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign class_idx   = class_idx_q;
  assign class_count = class_count_q;
  assign tie         = tie_q;

endmodule

// File: tb/tb_spike_decoder.sv
// Directed bench: several decoder instances with different window / width
// settings share one stimulus stream; each test checks one instance.
module tb_spike_decoder;

`ifdef SPIKE_DECODER_EARLY_EXIT_EN
  localparam int NDUT = 5;
`else
  localparam int NDUT = 4;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] spike = '0;

  logic       busy [NDUT];
  logic       ov   [NDUT];
  logic [2:0] ci   [NDUT];
  logic [7:0] cc   [NDUT];
  logic       tie  [NDUT];
  logic [1:0] cc_sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_decoder #(.WINDOW(4)) u_w4 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .input_spike(spike), .busy(busy[0]), .out_valid(ov[0]),
    .class_idx(ci[0]), .class_count(cc[0]), .tie(tie[0]));

  spike_decoder #(.WINDOW(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .input_spike(spike), .busy(busy[1]), .out_valid(ov[1]),
    .class_idx(ci[1]), .class_count(cc[1]), .tie(tie[1]));

  spike_decoder #(.CNT_W(2), .WINDOW(5)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .input_spike(spike), .busy(busy[2]), .out_valid(ov[2]),
    .class_idx(ci[2]), .class_count(cc_sat), .tie(tie[2]));
  assign cc[2] = {6'b0, cc_sat};

  spike_decoder #(.WINDOW(3)) u_w3 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .input_spike(spike), .busy(busy[3]), .out_valid(ov[3]),
    .class_idx(ci[3]), .class_count(cc[3]), .tie(tie[3]));

`ifdef SPIKE_DECODER_EARLY_EXIT_EN
  spike_decoder #(.WINDOW(100), .EARLY_THRESH(3)) u_ee (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .input_spike(spike), .busy(busy[4]), .out_valid(ov[4]),
    .class_idx(ci[4]), .class_count(cc[4]), .tie(tie[4]));
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; spike = '0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] v, input logic st);
    @(negedge clk); in_valid = 1'b1; spike = v; start = st;
  endtask

  task automatic idle();
    @(negedge clk); in_valid = 1'b0; spike = '0; start = 1'b0;
  endtask

  task automatic start_win();
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  // Counts rising edges until the chosen instance pulses out_valid
  task automatic wait_res(input int d, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov[d] && lat < 40);
    if (!ov[d]) chk("result_timeout", 32'(ov[d]), 32'd1);
  endtask

  int lat;
  logic seen;

  initial begin
    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_ov",   32'(ov[0]),   0);
    chk("rst_idx",  32'(ci[0]),   0);
    chk("rst_cnt",  32'(cc[0]),   0);
    chk("rst_tie",  32'(tie[0]),  0);

    // 1: WINDOW=4, argmax with latency
    start_win();
    chk("t1_busy", 32'(busy[0]), 1);
    send(8'h01, 0); send(8'h03, 0); send(8'h01, 0); send(8'h80, 0);
    idle();
    wait_res(0, lat);
    chk("t1_lat", 32'(lat),   9);
    chk("t1_idx", 32'(ci[0]), 0);
    chk("t1_cnt", 32'(cc[0]), 3);
    chk("t1_tie", 32'(tie[0]), 0);
    chk("t1_busy_done", 32'(busy[0]), 0);
    @(posedge clk); #1;
    chk("t1_pulse", 32'(ov[0]), 0);
    chk("t1_hold",  32'(cc[0]), 3);

    // 5: reset during SCAN aborts, then all-zero window
    start_win();
    send(8'h01, 0); send(8'h01, 0); send(8'h01, 0); send(8'h01, 0);
    idle();
    @(negedge clk); @(negedge clk);
    chk("t5_busy_scan", 32'(busy[0]), 1);
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("t5_busy", 32'(busy[0]), 0);
    chk("t5_cnt",  32'(cc[0]),   0);
    chk("t5_ov",   32'(ov[0]),   0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); seen |= ov[0];
    end
    chk("t5_no_ov", 32'(seen), 0);
    start_win();
    for (int i = 0; i < 4; i++) send(8'h00, 0);
    idle();
    wait_res(0, lat);
    chk("t5_zero_idx", 32'(ci[0]), 0);
    chk("t5_zero_cnt", 32'(cc[0]), 0);
    chk("t5_zero_tie", 32'(tie[0]), 1);

    // 2: WINDOW=2, tie goes to lowest index
    do_reset();
    start_win();
    send(8'h06, 0); send(8'h06, 0);
    idle();
    wait_res(1, lat);
    chk("t2_lat", 32'(lat),    9);
    chk("t2_idx", 32'(ci[1]),  1);
    chk("t2_cnt", 32'(cc[1]),  2);
    chk("t2_tie", 32'(tie[1]), 1);

    // 3: CNT_W=2 saturation
    do_reset();
    start_win();
    for (int i = 0; i < 5; i++) send(8'h04, 0);
    idle();
    wait_res(2, lat);
    chk("t3_idx", 32'(ci[2]),  2);
    chk("t3_cnt", 32'(cc[2]),  3);
    chk("t3_tie", 32'(tie[2]), 0);

    // 4: WINDOW=3 with gaps, start+in_valid in IDLE, start mid-window,
    //    and a trailing vector after the window closes
    do_reset();
    send(8'h80, 1);
    send(8'h02, 0);
    idle(); idle();
    send(8'h0A, 1);
    idle();
    send(8'h08, 0);
    send(8'h08, 0);
    idle();
    wait_res(3, lat);
    chk("t4_idx", 32'(ci[3]),  1);
    chk("t4_cnt", 32'(cc[3]),  2);
    chk("t4_tie", 32'(tie[3]), 1);

`ifdef SPIKE_DECODER_EARLY_EXIT_EN
    // 6: early exit at threshold 3
    do_reset();
    start_win();
    send(8'h10, 0); send(8'h10, 0); send(8'h10, 0);
    idle();
    wait_res(4, lat);
    chk("t6_lat", 32'(lat),    9);
    chk("t6_idx", 32'(ci[4]),  4);
    chk("t6_cnt", 32'(cc[4]),  3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_decoder.md
Name: spike_decoder

Overview:
- Output-side stage placed directly after the two-layer network top.
- Consumes the final layer's 8-bit spike vector, one vector per timestep.
- Counts spikes per output neuron over a fixed window of timesteps, then scans the counts sequentially and reports the winning class (argmax), its count, and a tie flag.
- Result is a one-cycle valid pulse, so the network can be driven by a frame sequencer.

Parameters:
- N_CLASS, 8, number of output neurons/classes (width of input_spike).
- CNT_W, 8, per-class counter width; counters saturate at 2^CNT_W-1.
- WINDOW, 100, timesteps (accepted in_valid cycles) per classification window; legal range 1..65535.
- IDX_W, 3, class index width; must satisfy 2^IDX_W >= N_CLASS.
- EARLY_THRESH, 32, early-exit count threshold (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  begin a new window; honoured only in IDLE.
- in_valid  input  1  input_spike holds one timestep this cycle.
- input_spike  input  N_CLASS  spike vector from the last layer.
- busy  output  1  high in ACCUM and SCAN.
- out_valid  output  1  one-cycle result pulse.
- class_idx  output  IDX_W  winning class index.
- class_count  output  CNT_W  spike count of the winning class.
- tie  output  1  another class equals the winning count.

Behaviour:
- One clock (clk); reset is synchronous and active-low (reset_n). All state changes on the rising edge of clk.
- Reset (reset_n=0 at a clk edge): state=IDLE, all counters=0, step counter=0, busy=0, out_valid=0, class_idx=0, class_count=0, tie=0.
- Reset mid-window or mid-scan aborts the window; no out_valid is produced.
- FSM has states IDLE, ACCUM, SCAN, DONE.
- IDLE:
  - start=1: clear all counters and the step counter, go to ACCUM.
  - in_valid is ignored.
  - Result outputs hold their last values.
- ACCUM:
  - Each in_valid=1 cycle: for every i with input_spike[i]=1, counter[i] increments and saturates at max (no wrap). The step counter increments.
  - The cycle accepting the WINDOW-th timestep goes to SCAN; that vector is counted.
  - in_valid=0 cycles do not advance the step counter.
  - start is ignored.
- SCAN:
  - Takes N_CLASS cycles, visiting index k = 0..N_CLASS-1.
  - Index 0 loads the running max and index; tie is cleared.
  - For k>0: if counter[k] > max, replace max and index and clear tie. If counter[k] = max, set tie.
  - Strict compare, so the lowest index wins ties.
  - in_valid is ignored.
- DONE:
  - Lasts one cycle: out_valid=1, class_idx/class_count/tie are presented, busy=0. Then go to IDLE.
  - Outputs remain stable until the next DONE or reset.
- Latency: out_valid rises N_CLASS+1 cycles after the clk edge that accepts the final timestep.
- All-zero window gives class_idx=0, class_count=0, tie=1 (N_CLASS>1).
- start and in_valid both high in IDLE: start is honoured, and that in_valid vector is not counted.
- start asserted in DONE is ignored; it must be presented in IDLE.

Optional Feature:
- Macro: SPIKE_DECODER_EARLY_EXIT_EN.
- Defined: in ACCUM, if any counter reaches EARLY_THRESH after the current update, go to SCAN immediately, even if fewer than WINDOW timesteps have arrived. The normal WINDOW end still applies.
- Undefined: EARLY_THRESH is unused, and every window runs exactly WINDOW timesteps.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum (IDLE/ACCUM/SCAN/DONE);
  - default constants N_CLASS=8, CNT_W=8, IDX_W=3;
  - a typedef for the count vector (array of N_CLASS CNT_W-bit counts).
- One sub-module, spike_counter_bank:
  - N_CLASS saturating counters with clear and enable inputs and a spike vector input;
  - exposes the count array.
  - The FSM and argmax scan stay in spike_decoder.

Test Plan:
1. WINDOW=4, start, then 4 valid vectors 0x01,0x03,0x01,0x80 -> out_valid exactly 9 cycles after the 4th vector; class_idx=0, class_count=3, tie=0.
2. WINDOW=2, vectors 0x06,0x06 -> class_idx=1, class_count=2, tie=1 (lowest index wins).
3. CNT_W=2, WINDOW=5, vector 0x04 five times -> class_count=3 (saturated), class_idx=2.
4. WINDOW=3, valid vectors interleaved with in_valid=0 gaps and a start pulse mid-window -> gaps and start are ignored; the result reflects exactly 3 vectors.
5. Assert reset_n=0 for one cycle during SCAN -> no out_valid; outputs and busy are 0. A new start with WINDOW all-zero vectors -> class_idx=0, class_count=0, tie=1.
6. With SPIKE_DECODER_EARLY_EXIT_EN, EARLY_THRESH=3, WINDOW=100, vector 0x10 every cycle -> SCAN entered after the 3rd vector; class_idx=4, class_count=3.
